pkt_ff_wr_ctrl: RTL

Write-side ingress controller for the async packet FIFO, directly upstream of `pkt_ff_wptr`. It takes a raw sop/eop-framed word stream with no backpressure and checks framing. It synchronizes the read pointer into `clk`, tracks free space, and writes accepted words into FIFO memory. Packets that overflow, carry an error, or break framing are aborted; the abort drives `pkt_ff_wptr` into its rewind-to-SOP path, so partial packets are never committed.

---
 rtl/pkt_ff_wr_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pkt_ff_wr_ctrl.sv
// pkt_ff_wr_ctrl: write-side ingress controller for the async packet FIFO.
// It checks the sop/eop framing of a raw word stream that has no backpressure,
// tracks free space against a synchronized read pointer, and writes accepted
// words into FIFO memory. Any packet that overflows, carries an error or
// breaks framing is aborted. The abort makes pkt_ff_wptr rewind to the
// packet's SOP, so a partial packet is never committed.
//
// Ports:
//   clk, rst_n                      write clock, async active-low reset
//   in_valid/sop/eop/error, in_data ingress word and its qualifiers
//   rptr_gry                        gray read pointer (read clock domain)
//   ff_valid/sop/eop/error          to pkt_ff_wptr (error = abort/rewind)
//   mem_wr_en/waddr/wdata           FIFO memory write port
//   full, fill                      space as seen by the write side
//   drop_cnt, frm_err_cnt           saturating statistics counters
module pkt_ff_wr_ctrl #(
  parameter int PTR_W  = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_error,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PTR_W-1:0]  rptr_gry,
  output logic              ff_valid,
  output logic              ff_sop,
  output logic              ff_eop,
  output logic              ff_error,
  output logic              mem_wr_en,
  output logic [PTR_W-1:0]  mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              full,
  output logic [PTR_W-1:0]  fill,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  frm_err_cnt
);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rptr_s1, rptr_s2, rptr_bin;
  logic [PTR_W-1:0]   wr_bin, sop_bin, wr_inc;

  // Two-flop synchronizer on the gray read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_s1 <= '0;
      rptr_s2 <= '0;
    end else begin
      rptr_s1 <= rptr_gry;
      rptr_s2 <= rptr_s1;
    end
  end

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    rptr_bin = '0;
    for (int i = 0; i < PTR_W; i++) rptr_bin[i] = ^(rptr_s2 >> i);
  end

  // full and fill come from registered state only. The synchronized rptr
  // lags the real one, so full can only be pessimistic.
  assign wr_inc = wr_bin + PTR_W'(1);
  assign full   = (wr_inc == rptr_bin);
  assign fill   = wr_bin - rptr_bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_bin      <= '0;
      sop_bin     <= '0;
      ff_valid    <= 1'b0;
      ff_sop      <= 1'b0;
      ff_eop      <= 1'b0;
      ff_error    <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      drop_cnt    <= '0;
      frm_err_cnt <= '0;
    end else begin
      ff_valid  <= 1'b0;
      ff_sop    <= 1'b0;
      ff_eop    <= 1'b0;
      ff_error  <= 1'b0;
      mem_wr_en <= 1'b0;
      if (in_valid) begin
        if (state == PKT) begin
          if (in_sop || in_error || full) begin
            // Abort: the offending word is not written. wr_bin rewinds now,
            // so a SOP in the next cycle reuses the aborted packet's slots.
            ff_valid <= 1'b1;
            ff_error <= 1'b1;
            wr_bin   <= sop_bin;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            if (in_sop && frm_err_cnt != '1) frm_err_cnt <= frm_err_cnt + CNT_W'(1);
            state <= in_eop ? IDLE : DROP;
          end else begin
            ff_valid  <= 1'b1;
            ff_eop    <= in_eop;
            mem_wr_en <= 1'b1;
            mem_waddr <= wr_bin;
            mem_wdata <= in_data;
            wr_bin    <= wr_inc;
            if (in_eop) state <= IDLE;
          end
        end else if (in_sop) begin
          // A SOP seen in IDLE, or a SOP that resyncs out of DROP.
          if (state == DROP && frm_err_cnt != '1) frm_err_cnt <= frm_err_cnt + CNT_W'(1);
          if (in_error || full) begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            state <= in_eop ? IDLE : DROP;
          end else begin
            sop_bin   <= wr_bin;
            ff_valid  <= 1'b1;
            ff_sop    <= 1'b1;
            ff_eop    <= in_eop;
            mem_wr_en <= 1'b1;
            mem_waddr <= wr_bin;
            mem_wdata <= in_data;
            wr_bin    <= wr_inc;
            state     <= in_eop ? IDLE : PKT;
          end
        end else if (state == IDLE) begin
          // A word outside any packet is a framing error.
          if (frm_err_cnt != '1) frm_err_cnt <= frm_err_cnt + CNT_W'(1);
        end else if (in_eop) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule
